// File: rtl/alu_pkg.sv
// Shared constants, opcode and state encodings for the ALU execute/writeback stage.
package alu_pkg;

    localparam int DWIDTH = 32;
    localparam int RWIDTH = 6;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_PASSB = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } exec_state_t;

    // Opcodes 12-15 are reserved and raise err instead of writing back.
    function automatic logic is_legal(input logic [3:0] code);
        return code <= 4'd11;
    endfunction

endpackage

// File: rtl/mul_seq_32bit.sv
// Shift-add multiplier: loads on start, then one iteration per clock for 32 clocks.
import alu_pkg::*;

module mul_seq_32bit (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic              done,
    output logic [DWIDTH-1:0] product
);

    logic [DWIDTH-1:0] mcand;
    logic [DWIDTH-1:0] mplier;
    logic [DWIDTH-1:0] acc;
    logic [4:0]        count;
    logic              running;

    // product is the accumulator after the current iteration, so it is final when done is high.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = running && (count == 5'd31);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (count == 5'd31) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage_32bit.sv
// Execute/writeback stage: single-cycle ALU ops at full rate, MUL stalls the stage for 32 cycles.
import alu_pkg::*;

module alu_exec_stage_32bit (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [RWIDTH-1:0] dst,
    output logic              wb_we,
    output logic [RWIDTH-1:0] wb_wa,
    output logic [DWIDTH-1:0] wb_wd,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              err,
    output logic              busy,
    output exec_state_t       state
);

    // Handshake: a transfer happens on a posedge where in_valid && in_ready; inputs are ignored otherwise.
    logic              accept;
    logic              legal;
    logic              mul_start;
    logic              mul_done;
    logic [DWIDTH-1:0] mul_product;
    logic [RWIDTH-1:0] mul_dst;
    logic [DWIDTH:0]   add_full;
    logic [DWIDTH-1:0] sub_res;
    logic [DWIDTH-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;

    assign in_ready  = rst && (state != MUL);
    assign busy      = (state == MUL);
    assign accept    = in_valid && in_ready;
    assign legal     = is_legal(op);
    assign mul_start = accept && (op == OP_MUL);
    assign add_full  = {1'b0, a} + {1'b0, b};
    assign sub_res   = a - b;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_full[DWIDTH-1:0];
                alu_c   = add_full[DWIDTH];
                alu_v   = (a[DWIDTH-1] == b[DWIDTH-1]) && (add_full[DWIDTH-1] != a[DWIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_c   = (a >= b);
                alu_v   = (a[DWIDTH-1] != b[DWIDTH-1]) && (sub_res[DWIDTH-1] != a[DWIDTH-1]);
            end
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_SLL:   alu_res = a << b[4:0];
            OP_SRL:   alu_res = a >> b[4:0];
            OP_SRA:   alu_res = $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:   alu_res = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_res = {{(DWIDTH-1){1'b0}}, (a < b)};
            OP_PASSB: alu_res = b;
            default:  alu_res = '0;
        endcase
    end

    mul_seq_32bit u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // wb_wa/wb_wd/flags only change on a writeback, so they hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            wb_we   <= 1'b0;
            wb_wa   <= '0;
            wb_wd   <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            err     <= 1'b0;
            mul_dst <= '0;
        end else begin
            wb_we <= 1'b0;
            err   <= 1'b0;
            if (state == MUL) begin
                if (mul_done) begin
                    state  <= WB;
                    wb_we  <= 1'b1;
                    wb_wa  <= mul_dst;
                    wb_wd  <= mul_product;
                    flag_z <= (mul_product == '0);
                    flag_c <= 1'b0;
                    flag_v <= 1'b0;
                end
            end else if (accept) begin
                if (!legal) begin
                    state <= IDLE;
                    err   <= 1'b1;
                end else if (op == OP_MUL) begin
                    state   <= MUL;
                    mul_dst <= dst;
                end else begin
                    state  <= WB;
                    wb_we  <= 1'b1;
                    wb_wa  <= dst;
                    wb_wd  <= alu_res;
                    flag_z <= (alu_res == '0);
                    flag_c <= alu_c;
                    flag_v <= alu_v;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
